// File: rtl/bist_fault_sequencer.sv
// bist_fault_sequencer
// Runs a stuck-at fault-grading campaign on the BIST datapath: one
// fault-free golden session, then for every site a stuck-at-1 session
// followed by a stuck-at-0 session. Each faulty signature is compared with
// the golden one, and the per-site detection maps and counts are updated.
// All outputs come straight from flops. The output registers are loaded
// from the next state, so they change on the same edge as the state.
module bist_fault_sequencer #(
    parameter int NSITES = 51,
    parameter int SIGW   = 5,
    parameter int NPAT   = 960,
    parameter int RSTCYC = 2,
    parameter int CW     = $clog2(NSITES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIGW-1:0]   signature,
    output logic              bist_rst,
    output logic              bist_enb,
    output logic [NSITES-1:0] fault_places,
    output logic [NSITES-1:0] fault_control,
    output logic              busy,
    output logic              done,
    output logic [SIGW-1:0]   golden,
    output logic [CW-1:0]     count1,
    output logic [CW-1:0]     count0,
    output logic [NSITES-1:0] det1_map,
    output logic [NSITES-1:0] det0_map
);

    // Site index width. A one-site build still gets a one-bit index.
    localparam int SW = (NSITES > 1) ? $clog2(NSITES) : 1;

    // A single counter times both the reset and the run phases, so it is
    // sized for the longer of the two.
    localparam int CMAX = (NPAT > RSTCYC) ? NPAT : RSTCYC;
    localparam int CNTW = $clog2(CMAX + 1);

    localparam logic [SW-1:0]   LAST_SITE = SW'(NSITES - 1);
    localparam logic [CNTW-1:0] RST_LAST  = CNTW'(RSTCYC - 1);
    localparam logic [CNTW-1:0] RUN_LAST  = CNTW'(NPAT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRST  = 3'd1,
        GRUN  = 3'd2,
        S1RST = 3'd3,
        S1RUN = 3'd4,
        S0RST = 3'd5,
        S0RUN = 3'd6,
        DONE  = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]     site_q, site_d;
    logic [SIGW-1:0]   golden_q, golden_d;
    logic [CW-1:0]     count1_q, count1_d;
    logic [CW-1:0]     count0_q, count0_d;
    logic [NSITES-1:0] det1_q, det1_d;
    logic [NSITES-1:0] det0_q, det0_d;
    logic [NSITES-1:0] places_q, places_d;
    logic [NSITES-1:0] control_q, control_d;
    logic              bist_rst_q, bist_rst_d;
    logic              bist_enb_q, bist_enb_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // One-hot site select for the upcoming site. Site index i drives bit
    // NSITES-1-i, so the walk starts at the MSB and ends at bit 0.
    logic [NSITES-1:0] site_onehot_d;

    logic rst_phase_end;
    logic run_phase_end;
    logic sig_differs;

    assign rst_phase_end = (cnt_q == RST_LAST);
    assign run_phase_end = (cnt_q == RUN_LAST);
    assign sig_differs   = (signature != golden_q);

    genvar gi;
    generate
        for (gi = 0; gi < NSITES; gi = gi + 1) begin : g_onehot
            assign site_onehot_d[gi] = (site_d == SW'(NSITES - 1 - gi));
        end
    endgenerate

    // Next-state logic: phase sequencing, site walk, golden capture and
    // detection bookkeeping.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        site_d   = site_q;
        golden_d = golden_q;
        count1_d = count1_q;
        count0_d = count0_q;
        det1_d   = det1_q;
        det0_d   = det0_q;

        case (state_q)
            IDLE, DONE: begin
                // A new campaign discards every result of the previous one.
                if (start) begin
                    state_d  = GRST;
                    cnt_d    = '0;
                    site_d   = '0;
                    golden_d = '0;
                    count1_d = '0;
                    count0_d = '0;
                    det1_d   = '0;
                    det0_d   = '0;
                end
            end

            GRST: begin
                if (rst_phase_end) begin
                    state_d = GRUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end

            GRUN: begin
                if (run_phase_end) begin
                    golden_d = signature;
                    state_d  = S1RST;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end

            S1RST: begin
                if (rst_phase_end) begin
                    state_d = S1RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end

            S1RUN: begin
                if (run_phase_end) begin
                    // The fault site currently driven is exactly the bit
                    // to mark in the detection map.
                    if (sig_differs) begin
                        det1_d   = det1_q | places_q;
                        count1_d = count1_q + CW'(1);
                    end
                    state_d = S0RST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end

            S0RST: begin
                if (rst_phase_end) begin
                    state_d = S0RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end

            S0RUN: begin
                if (run_phase_end) begin
                    if (sig_differs) begin
                        det0_d   = det0_q | places_q;
                        count0_d = count0_q + CW'(1);
                    end
                    cnt_d = '0;
                    if (site_q == LAST_SITE) begin
                        state_d = DONE;
                    end else begin
                        site_d  = site_q + SW'(1);
                        state_d = S1RST;
                    end
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up
    // with the state register.
    always_comb begin
        places_d   = '0;
        control_d  = '0;
        bist_rst_d = 1'b0;
        bist_enb_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_d)
            GRST: begin
                bist_enb_d = 1'b1;
                busy_d     = 1'b1;
            end
            GRUN: begin
                bist_rst_d = 1'b1;
                bist_enb_d = 1'b1;
                busy_d     = 1'b1;
            end
            S1RST: begin
                places_d   = site_onehot_d;
                control_d  = site_onehot_d;
                bist_enb_d = 1'b1;
                busy_d     = 1'b1;
            end
            S1RUN: begin
                places_d   = site_onehot_d;
                control_d  = site_onehot_d;
                bist_rst_d = 1'b1;
                bist_enb_d = 1'b1;
                busy_d     = 1'b1;
            end
            S0RST: begin
                places_d   = site_onehot_d;
                control_d  = ~site_onehot_d;
                bist_enb_d = 1'b1;
                busy_d     = 1'b1;
            end
            S0RUN: begin
                places_d   = site_onehot_d;
                control_d  = ~site_onehot_d;
                bist_rst_d = 1'b1;
                bist_enb_d = 1'b1;
                busy_d     = 1'b1;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                places_d = '0;
            end
        endcase
    end

    // State, counters, results and registered outputs. Reset drops any
    // partial campaign.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            site_q     <= '0;
            golden_q   <= '0;
            count1_q   <= '0;
            count0_q   <= '0;
            det1_q     <= '0;
            det0_q     <= '0;
            places_q   <= '0;
            control_q  <= '0;
            bist_rst_q <= 1'b0;
            bist_enb_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            site_q     <= site_d;
            golden_q   <= golden_d;
            count1_q   <= count1_d;
            count0_q   <= count0_d;
            det1_q     <= det1_d;
            det0_q     <= det0_d;
            places_q   <= places_d;
            control_q  <= control_d;
            bist_rst_q <= bist_rst_d;
            bist_enb_q <= bist_enb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bist_rst      = bist_rst_q;
    assign bist_enb      = bist_enb_q;
    assign fault_places  = places_q;
    assign fault_control = control_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign golden        = golden_q;
    assign count1        = count1_q;
    assign count0        = count0_q;
    assign det1_map      = det1_q;
    assign det0_map      = det0_q;

endmodule

// File: tb/tb_bist_fault_sequencer.sv
// Testbench for bist_fault_sequencer (NSITES=4, NPAT=8, RSTCYC=2).
// A small BIST model counts enabled run cycles. Its signature is flipped
// for selected faults according to the current mode. The driver pushes the
// expected fault-site sequence and the final results into queues, and a
// monitor compares them as the DUT presents them.
module tb_bist_fault_sequencer;

    localparam int NS  = 4;
    localparam int SGW = 5;
    localparam int NP  = 8;
    localparam int RC  = 2;
    localparam int CWL = 3;
    localparam int CAMPAIGN_CYC = (2 * NS + 1) * (RC + NP);

    logic            clk   = 1'b0;
    logic            rst   = 1'b0;
    logic            start = 1'b0;
    logic [SGW-1:0]  signature;
    logic            bist_rst, bist_enb, busy, done;
    logic [NS-1:0]   fault_places, fault_control, det1_map, det0_map;
    logic [SGW-1:0]  golden;
    logic [CWL-1:0]  count1, count0;

    bist_fault_sequencer #(
        .NSITES(NS), .SIGW(SGW), .NPAT(NP), .RSTCYC(RC), .CW(CWL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .signature(signature),
        .bist_rst(bist_rst), .bist_enb(bist_enb),
        .fault_places(fault_places), .fault_control(fault_control),
        .busy(busy), .done(done), .golden(golden),
        .count1(count1), .count0(count0),
        .det1_map(det1_map), .det0_map(det0_map)
    );

    bit clk_run = 1'b1;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int mode = 0;

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // BIST model: accumulator cleared in session reset, counting while
    // running. Mode 0: faults invisible. Mode 1: only stuck-at-0 at the
    // 4'b0100 site is visible. Mode 2: every fault is visible.
    logic [SGW-1:0] acc = '0;
    logic           flip;

    always @(posedge clk) begin
        if (!bist_rst)
            acc <= '0;
        else if (bist_enb)
            acc <= acc + 5'd1;
    end

    always_comb begin
        flip = 1'b0;
        if (mode == 1)
            flip = (fault_places == 4'b0100) && ((fault_control & fault_places) == 4'b0000);
        else if (mode == 2)
            flip = (fault_places != 4'b0000);
        signature = acc ^ {4'b0000, flip};
    end

    typedef struct packed {
        logic [4:0] g;
        logic [2:0] c1;
        logic [2:0] c0;
        logic [3:0] m1;
        logic [3:0] m0;
    } res_t;

    // Expected {fault_places, fault_control, bist_enb} at every change of
    // the fault outputs during one campaign; the last entry is DONE.
    logic [8:0] pf_tab [9] = '{
        9'b1000_1000_1, 9'b1000_0111_1,
        9'b0100_0100_1, 9'b0100_1011_1,
        9'b0010_0010_1, 9'b0010_1101_1,
        9'b0001_0001_1, 9'b0001_1110_1,
        9'b0000_0000_0
    };

    logic [8:0] exp_pf [$];
    res_t       exp_res [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_campaign(input res_t r);
        exp_res.push_back(r);
        for (int k = 0; k < 9; k++) exp_pf.push_back(pf_tab[k]);
        $display("push campaign mode=%0d golden=%0d c1=%0d c0=%0d m1=%b m0=%b",
                 mode, r.g, r.c1, r.c0, r.m1, r.m0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_bist_rst"}, 32'(bist_rst), 0);
        chk({tag, "_bist_enb"}, 32'(bist_enb), 0);
        chk({tag, "_places"}, 32'(fault_places), 0);
        chk({tag, "_control"}, 32'(fault_control), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_golden"}, 32'(golden), 0);
        chk({tag, "_count1"}, 32'(count1), 0);
        chk({tag, "_count0"}, 32'(count0), 0);
        chk({tag, "_det1"}, 32'(det1_map), 0);
        chk({tag, "_det0"}, 32'(det0_map), 0);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        chk("done_within_budget", 32'(done), 1);
    endtask

    // Monitor: compares fault-site changes, bist_rst rise delay and final
    // results against the queued expectations.
    initial begin : monitor
        logic [7:0] pf_prev;
        logic       busy_prev, done_prev, brst_prev;
        int         t0, t_chg;
        logic [8:0] e;
        res_t       r;
        pf_prev = '0; busy_prev = 0; done_prev = 0; brst_prev = 0;
        t0 = 0; t_chg = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pf_prev = '0; busy_prev = 0; done_prev = 0; brst_prev = 0;
            end else begin
                if (busy && !busy_prev) begin
                    t0 = cyc;
                    t_chg = cyc;
                end
                if ({fault_places, fault_control} != pf_prev) begin
                    t_chg = cyc;
                    if (exp_pf.size() == 0) begin
                        chk("pf_change_expected", 0, 1);
                    end else begin
                        e = exp_pf.pop_front();
                        $display("site change places=%b control=%b enb=%b", fault_places, fault_control, bist_enb);
                        chk("fault_outputs", 32'({fault_places, fault_control}), 32'(e[8:1]));
                        chk("bist_enb_at_change", 32'(bist_enb), 32'(e[0]));
                        chk("bist_rst_at_change", 32'(bist_rst), 0);
                    end
                end
                if (bist_rst && !brst_prev)
                    chk("bist_rst_rise_delay", 32'(cyc - t_chg), RC);
                if (done && !done_prev) begin
                    if (exp_res.size() == 0) begin
                        chk("result_expected", 0, 1);
                    end else begin
                        r = exp_res.pop_front();
                        $display("campaign done golden=%0d c1=%0d c0=%0d m1=%b m0=%b cycles=%0d",
                                 golden, count1, count0, det1_map, det0_map, cyc - t0);
                        chk("golden", 32'(golden), 32'(r.g));
                        chk("count1", 32'(count1), 32'(r.c1));
                        chk("count0", 32'(count0), 32'(r.c0));
                        chk("det1_map", 32'(det1_map), 32'(r.m1));
                        chk("det0_map", 32'(det0_map), 32'(r.m0));
                        chk("campaign_cycles", 32'(cyc - t0), CAMPAIGN_CYC);
                        chk("busy_low_at_done", 32'(busy), 0);
                    end
                end
                pf_prev   = {fault_places, fault_control};
                busy_prev = busy;
                done_prev = done;
                brst_prev = bist_rst;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver
    initial begin : driver
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("por");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_without_start", 32'(busy), 0);

        // Campaign A: faults invisible.
        mode = 0;
        push_campaign('{g: 5'd7, c1: 3'd0, c0: 3'd0, m1: 4'b0000, m0: 4'b0000});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        chk("bist_enb_after_start", 32'(bist_enb), 1);
        chk("bist_rst_after_start", 32'(bist_rst), 0);
        wait_done(CAMPAIGN_CYC + 20);
        repeat (3) @(negedge clk);

        // Campaign B: all faults visible, start held high while busy.
        mode = 2;
        push_campaign('{g: 5'd7, c1: 3'd4, c0: 3'd4, m1: 4'b1111, m0: 4'b1111});
        start = 1'b1;
        wait_done(CAMPAIGN_CYC + 20);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("done_held", 32'(done), 1);
        chk("count1_held", 32'(count1), 4);

        // Campaign C: start pulse in DONE clears results on that edge.
        mode = 1;
        push_campaign('{g: 5'd7, c1: 3'd0, c0: 3'd1, m1: 4'b0000, m0: 4'b0100});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_count1_clear", 32'(count1), 0);
        chk("restart_count0_clear", 32'(count0), 0);
        chk("restart_det1_clear", 32'(det1_map), 0);
        chk("restart_det0_clear", 32'(det0_map), 0);
        chk("restart_golden_clear", 32'(golden), 0);
        chk("restart_done_clear", 32'(done), 0);
        chk("restart_busy", 32'(busy), 1);
        wait_done(CAMPAIGN_CYC + 20);
        repeat (2) @(negedge clk);

        // Campaign D: reset mid-campaign with the clock stopped.
        mode = 2;
        push_campaign('{g: 5'd7, c1: 3'd4, c0: 3'd4, m1: 4'b1111, m0: 4'b1111});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        chk("midrun_busy", 32'(busy), 1);
        clk_run = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_zero("async_rst");
        $display("reset applied at cycle %0d", cyc);
        exp_pf.delete();
        exp_res.delete();
        start = 1'b1;
        #5;
        clk_run = 1'b1;
        repeat (3) @(negedge clk);
        chk("start_ignored_in_rst", 32'(busy), 0);
        start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("wait_for_new_start", 32'(busy), 0);
        chk("no_partial_results", 32'(count1), 0);

        // Campaign E: fresh run after reset.
        push_campaign('{g: 5'd7, c1: 3'd4, c0: 3'd4, m1: 4'b1111, m0: 4'b1111});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(CAMPAIGN_CYC + 20);
        repeat (2) @(negedge clk);
        chk("queues_drained", 32'(exp_pf.size() + exp_res.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
